// File: rtl/fir_pkg.sv
// rtl/fir_pkg.sv - shared FSM encoding and sizing/saturation helpers for the FIR MAC
package fir_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FETCH = 2'd1,
        ST_MAC   = 2'd2,
        ST_OUT   = 2'd3
    } fir_state_e;

    // Smallest number of bits able to index 'value' distinct entries.
    function automatic int fir_clog2(input int value);
        int result;
        result = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < value) begin
                result = i + 1;
            end
        end
        return result;
    endfunction

    // Largest value representable in a signed word of 'width' bits.
    function automatic longint SAT_MAX(input int width);
        return (longint'(1) <<< (width - 1)) - longint'(1);
    endfunction

    // Smallest value representable in a signed word of 'width' bits.
    function automatic longint SAT_MIN(input int width);
        return -(longint'(1) <<< (width - 1));
    endfunction

endpackage

// File: rtl/fir_round_sat.sv
// rtl/fir_round_sat.sv - round-half-up shift and clip of the accumulator to the output width
module fir_round_sat
    import fir_pkg::*;
#(
    parameter int ACC_W = 24,
    parameter int OUT_W = 16,
    parameter int SHIFT = 0
) (
    input  logic signed [ACC_W-1:0] acc_i,
    output logic signed [OUT_W-1:0] value_o,
    output logic                    clip_o
);

    // One guard bit so adding the rounding bias can never wrap.
    localparam int WIDE_W = ACC_W + 1;
    localparam logic signed [WIDE_W-1:0] BIAS =
        (SHIFT > 0) ? (WIDE_W'(1) << ((SHIFT > 0) ? SHIFT - 1 : 0)) : '0;
    localparam logic signed [WIDE_W-1:0] MAX_W = WIDE_W'(SAT_MAX(OUT_W));
    localparam logic signed [WIDE_W-1:0] MIN_W = WIDE_W'(SAT_MIN(OUT_W));

    if (OUT_W > ACC_W) begin : g_out_w_check
        $error("fir_round_sat: OUT_W must not exceed ACC_W");
    end

    logic signed [WIDE_W-1:0] biased;
    logic signed [WIDE_W-1:0] shifted;

    // Add half an LSB of the shifted result, arithmetic shift, then clip to the output range.
    always_comb begin
        biased  = {acc_i[ACC_W-1], acc_i} + BIAS;
        shifted = biased >>> SHIFT;
        value_o = shifted[OUT_W-1:0];
        clip_o  = 1'b0;
        if (shifted > MAX_W) begin
            value_o = MAX_W[OUT_W-1:0];
            clip_o  = 1'b1;
        end else if (shifted < MIN_W) begin
            value_o = MIN_W[OUT_W-1:0];
            clip_o  = 1'b1;
        end
    end

endmodule

// File: rtl/fir_mac_seq.sv
// rtl/fir_mac_seq.sv - sequential multiply-accumulate over a delay-chain snapshot and SRAM coefficients
module fir_mac_seq
    import fir_pkg::*;
#(
    parameter int NUM_TAPS = 10,
    parameter int DATA_W   = 3,
    parameter int COEFF_W  = 16,
    parameter int ACC_W    = 24,
    parameter int OUT_W    = 16,
    parameter int SHIFT    = 0,
    localparam int ADDR_W  = fir_clog2(NUM_TAPS)
) (
    input  logic                         iClk12M,
    input  logic                         iRst,
    input  logic                         iStart,
    input  logic [NUM_TAPS*DATA_W-1:0]   iDelay,
    input  logic [COEFF_W-1:0]           iCoeff,
    output logic                         oCoeffRd,
    output logic [ADDR_W-1:0]            oCoeffAddr,
    output logic                         oBusy,
    output logic [OUT_W-1:0]             oMac,
    output logic                         oMacValid,
    output logic                         oSat,
    output logic                         oOverrun
);

    if (NUM_TAPS < 2) begin : g_taps_check
        $error("fir_mac_seq: NUM_TAPS must be at least 2");
    end
    if (ACC_W < DATA_W + COEFF_W + fir_clog2(NUM_TAPS)) begin : g_acc_w_check
        $error("fir_mac_seq: ACC_W too small to hold the full-precision sum");
    end

    localparam logic [ADDR_W-1:0] LAST_TAP = ADDR_W'(NUM_TAPS - 1);

    fir_state_e                    state_q, state_d;
    logic [ADDR_W-1:0]             cnt_q, cnt_d;
    logic [NUM_TAPS*DATA_W-1:0]    snap_q, snap_d;
    logic signed [ACC_W-1:0]       acc_q, acc_d;
    logic [OUT_W-1:0]              mac_q, mac_d;
    logic                          valid_q, valid_d;
    logic                          sat_q, sat_d;
    logic                          ovr_q, ovr_d;

    logic [DATA_W-1:0]             tap_sel;
    logic signed [ACC_W-1:0]       coeff_ext;
    logic signed [ACC_W-1:0]       tap_ext;
    logic signed [ACC_W-1:0]       product;
    logic signed [OUT_W-1:0]       rs_value;
    logic                          rs_clip;

    // Both operands are widened to the accumulator width so the product is exact.
    assign tap_sel   = snap_q[cnt_q*DATA_W +: DATA_W];
    assign coeff_ext = {{(ACC_W-COEFF_W){iCoeff[COEFF_W-1]}}, iCoeff};
    assign tap_ext   = {{(ACC_W-DATA_W){tap_sel[DATA_W-1]}}, tap_sel};
    assign product   = coeff_ext * tap_ext;

    fir_round_sat #(
        .ACC_W (ACC_W),
        .OUT_W (OUT_W),
        .SHIFT (SHIFT)
    ) u_round_sat (
        .acc_i   (acc_q),
        .value_o (rs_value),
        .clip_o  (rs_clip)
    );

    // Next-state, datapath updates and SRAM read strobes; the read issued in cycle k lands in cycle k+1.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        snap_d     = snap_q;
        acc_d      = acc_q;
        mac_d      = mac_q;
        valid_d    = 1'b0;
        sat_d      = 1'b0;
        ovr_d      = ovr_q;
        oCoeffRd   = 1'b0;
        oCoeffAddr = '0;

        if (iStart && (state_q != ST_IDLE)) begin
            ovr_d = 1'b1;
        end

        case (state_q)
            ST_IDLE: begin
                if (iStart) begin
                    state_d = ST_FETCH;
                    snap_d  = iDelay;
                    acc_d   = '0;
                    cnt_d   = '0;
                end
            end
            ST_FETCH: begin
                oCoeffRd   = 1'b1;
                oCoeffAddr = '0;
                cnt_d      = '0;
                state_d    = ST_MAC;
            end
            ST_MAC: begin
                acc_d = acc_q + product;
                if (cnt_q == LAST_TAP) begin
                    state_d = ST_OUT;
                end else begin
                    oCoeffRd   = 1'b1;
                    oCoeffAddr = cnt_q + ADDR_W'(1);
                    cnt_d      = cnt_q + ADDR_W'(1);
                end
            end
            ST_OUT: begin
                mac_d   = rs_value;
                sat_d   = rs_clip;
                valid_d = 1'b1;
                cnt_d   = '0;
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and datapath registers; reset abandons any computation in flight.
    always_ff @(posedge iClk12M) begin
        if (iRst) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            snap_q  <= '0;
            acc_q   <= '0;
            mac_q   <= '0;
            valid_q <= 1'b0;
            sat_q   <= 1'b0;
            ovr_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            snap_q  <= snap_d;
            acc_q   <= acc_d;
            mac_q   <= mac_d;
            valid_q <= valid_d;
            sat_q   <= sat_d;
            ovr_q   <= ovr_d;
        end
    end

    assign oBusy     = (state_q != ST_IDLE);
    assign oMac      = mac_q;
    assign oMacValid = valid_q;
    assign oSat      = sat_q;
    assign oOverrun  = ovr_q;

endmodule
